// File: rtl/spi_peripheral.sv
// SPI target: oversampled SCLK/CS_n/COPI, 8-bit MSB-first shifting in modes 0-3,
// single-entry TX holding register and one-cycle RX valid pulse.
module spi_peripheral #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0]  IDLE_BYTE   = 8'h00
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [1:0] i_mode,
    input  logic [7:0] i_tx,
    input  logic       i_tx_valid,
    output logic       o_tx_ready,
    output logic       o_tx_underrun,
    output logic [7:0] o_rx,
    output logic       o_rx_valid,
    output logic       o_busy,
    input  logic       i_sclk,
    input  logic       i_cs_n,
    input  logic       i_copi,
    output logic       o_cipo,
    output logic       o_cipo_oe
);

    typedef enum logic {
        S_IDLE,
        S_ACTIVE
    } state_e;

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] copi_sync_q, copi_sync_d;
    logic                   sclk_prev_q, cs_prev_q;

    state_e     state_q, state_d;
    logic [1:0] mode_q, mode_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] rx_shift_q, rx_shift_d;
    logic [7:0] tx_shift_q, tx_shift_d;
    logic [7:0] hold_q, hold_d;
    logic       hold_full_q, hold_full_d;
    logic [7:0] rx_q, rx_d;
    logic       rx_valid_q, rx_valid_d;
    logic       underrun_q, underrun_d;

    logic sclk_s, cs_s, copi_s;
    logic sclk_rise, sclk_fall, cs_fall, cs_rise;
    logic lead_edge, trail_edge, sample_edge, shift_edge;
    logic load;

    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], i_sclk};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], i_cs_n};
        copi_sync_d = {copi_sync_q[SYNC_STAGES-2:0], i_copi};
    end

    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s   = cs_sync_q[SYNC_STAGES-1];
    assign copi_s = copi_sync_q[SYNC_STAGES-1];

    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign cs_fall   = ~cs_s & cs_prev_q;
    assign cs_rise   = cs_s & ~cs_prev_q;

    // mode_q = {CPOL, CPHA}; leading edge leaves the idle SCLK level
    assign lead_edge   = mode_q[1] ? sclk_fall : sclk_rise;
    assign trail_edge  = mode_q[1] ? sclk_rise : sclk_fall;
    assign sample_edge = mode_q[0] ? trail_edge : lead_edge;
    assign shift_edge  = mode_q[0] ? lead_edge : trail_edge;

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        bit_cnt_d   = bit_cnt_q;
        rx_shift_d  = rx_shift_q;
        tx_shift_d  = tx_shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        rx_d        = rx_q;
        rx_valid_d  = 1'b0;
        underrun_d  = 1'b0;
        load        = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (cs_fall) begin
                    state_d    = S_ACTIVE;
                    mode_d     = i_mode;
                    bit_cnt_d  = 3'd0;
                    rx_shift_d = 8'h00;
                    load       = 1'b1;
                end
            end
            S_ACTIVE: begin
                if (cs_rise) begin
                    state_d    = S_IDLE;
                    bit_cnt_d  = 3'd0;
                    rx_shift_d = 8'h00;
                    tx_shift_d = 8'h00;
                end else if (sample_edge) begin
                    rx_shift_d = {rx_shift_q[6:0], copi_s};
                    bit_cnt_d  = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        rx_d       = rx_shift_d;
                        rx_valid_d = 1'b1;
                        load       = 1'b1;
                    end
                // first shift edge of each byte only presents the loaded bit7
                end else if (shift_edge && bit_cnt_q != 3'd0) begin
                    tx_shift_d = {tx_shift_q[6:0], 1'b0};
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (load) begin
            if (hold_full_q) begin
                tx_shift_d  = hold_q;
                hold_full_d = 1'b0;
            end else begin
                tx_shift_d = IDLE_BYTE;
                underrun_d = 1'b1;
            end
        end

        if (i_tx_valid && !hold_full_q) begin
            hold_d      = i_tx;
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            copi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
            state_q     <= S_IDLE;
            mode_q      <= 2'd0;
            bit_cnt_q   <= 3'd0;
            rx_shift_q  <= 8'h00;
            tx_shift_q  <= 8'h00;
            hold_q      <= 8'h00;
            hold_full_q <= 1'b0;
            rx_q        <= 8'h00;
            rx_valid_q  <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            cs_sync_q   <= cs_sync_d;
            copi_sync_q <= copi_sync_d;
            sclk_prev_q <= sclk_s;
            cs_prev_q   <= cs_s;
            state_q     <= state_d;
            mode_q      <= mode_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_shift_q  <= rx_shift_d;
            tx_shift_q  <= tx_shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            rx_q        <= rx_d;
            rx_valid_q  <= rx_valid_d;
            underrun_q  <= underrun_d;
        end
    end

    assign o_busy        = (state_q == S_ACTIVE);
    assign o_cipo_oe     = o_busy;
    assign o_cipo        = o_busy & tx_shift_q[7];
    assign o_tx_ready    = ~hold_full_q;
    assign o_tx_underrun = underrun_q;
    assign o_rx          = rx_q;
    assign o_rx_valid    = rx_valid_q;

endmodule
